// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter.
// Holds the FSM state encoding and the digit constants used by the
// add-3 correction step and the overflow clamp.
package bcd_pkg;

  // Converter FSM states: IDLE waits for start, SHIFT runs one
  // double-dabble step per clock, DONE publishes the result.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // A digit at or above this value gets +3 before the next shift so that
  // doubling it carries correctly into the next decimal digit.
  localparam logic [3:0] BCD_ADD3_THRESH = 4'd5;

  // Digit value used to fill every position when the input is too large
  // to display.
  localparam logic [3:0] BCD_NINE = 4'h9;

endpackage

// File: rtl/bcd_add3_digit.sv
// Single-digit double-dabble correction: out = in >= 5 ? in + 3 : in.
// Purely combinational; the 4-bit result wraps and never carries into
// the neighbouring digit.
module bcd_add3_digit
  import bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  // Add 3 to digits that would otherwise overflow past 9 when doubled.
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= BCD_ADD3_THRESH) begin
      o_digit = i_digit + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential binary-to-packed-BCD converter (double dabble, one input bit
// per clock). Feeds the six-digit seven-segment controller.
//
// Handshake: start is sampled only while idle (busy=0); the edge that sees
// start=1 captures bin_in. busy stays high through the shift and publish
// phases. done pulses for exactly one cycle, and from that cycle on bcd_out
// and overflow hold the new result until the next done. start while busy
// is dropped, not queued. A start presented during the done cycle is
// accepted on the following edge, giving back-to-back conversions every
// BIN_W+2 cycles.
//
// Optional build macro BCD_BLANK_MASK_EN adds the blank_mask output, a
// leading-zero mask updated together with done.
module bin_to_bcd
  import bcd_pkg::*;
#(
  parameter int BIN_W   = 20,
  parameter int DIGITS  = 6,
  parameter int MAX_VAL = 999999
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
`ifdef BCD_BLANK_MASK_EN
  output logic [DIGITS-1:0]     blank_mask,
`endif
  output logic [1:0]            dbg_state
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [BIN_W-1:0]   r_bin;
  logic [BCD_W-1:0]   r_scratch;
  logic               r_ovf_pend;
  logic               r_busy;
  logic               r_done;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_ovf;

  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_result;
  logic               w_in_over;

  // Overflow is decided once, on the value being captured.
  assign w_in_over = (32'(bin_in) > 32'(MAX_VAL));

  // Clamp to all nines when the captured value cannot be displayed.
  assign w_result = r_ovf_pend ? {DIGITS{BCD_NINE}} : r_scratch;

  // One add-3 corrector per scratch digit, applied before every shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .i_digit (r_scratch[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

`ifdef BCD_BLANK_MASK_EN
  logic [DIGITS-1:0]  r_mask;
  logic [DIGITS-1:0]  w_mask;
  logic               w_zero_hi;

  // Digit i is a leading zero when it and every higher digit are zero;
  // digit 0 is never blanked so a value of zero still shows "0".
  always_comb begin
    w_mask    = '0;
    w_zero_hi = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_zero_hi = w_zero_hi && (w_result[4*i +: 4] == 4'd0);
      w_mask[i] = w_zero_hi;
    end
  end

  assign blank_mask = r_mask;
`endif

  // Converter FSM: capture, shift BIN_W times, then publish the result.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bin      <= '0;
      r_scratch  <= '0;
      r_ovf_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
`ifdef BCD_BLANK_MASK_EN
      r_mask     <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_bin      <= bin_in;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= w_in_over;
            r_busy     <= 1'b1;
            r_state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Corrected digits and the binary register shift left as one word.
          r_scratch <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
          r_bin     <= {r_bin[BIN_W-2:0], 1'b0};
          r_cnt     <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_bcd   <= w_result;
          r_ovf   <= r_ovf_pend;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
`ifdef BCD_BLANK_MASK_EN
          r_mask  <= w_mask;
`endif
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign bcd_out   = r_bcd;
  assign overflow  = r_ovf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd: directed cases for latency, clamp,
// ignored starts, back-to-back and mid-conversion reset, then random
// values compared against a decimal-arithmetic reference model.
// Build with BCD_BLANK_MASK_EN defined to also check blank_mask.
module tb_bin_to_bcd;

  localparam int BIN_W = 20;
  localparam int DIGITS = 6;
  localparam int LAT = BIN_W + 1;
  localparam int EW = 1 + 4 * DIGITS + DIGITS;

  logic                 sys_clk;
  logic                 rst_n;
  logic                 start;
  logic [BIN_W-1:0]     bin_in;
  logic                 busy;
  logic                 done;
  logic [4*DIGITS-1:0]  bcd_out;
  logic                 overflow;
  logic [1:0]           dbg_state;
`ifdef BCD_BLANK_MASK_EN
  logic [DIGITS-1:0]    blank_mask;
`endif

  int n_checks;
  int n_errors;
  logic [EW-1:0] exp_q[$];

  bin_to_bcd #(.BIN_W(BIN_W), .DIGITS(DIGITS), .MAX_VAL(999999)) u_dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .start     (start),
    .bin_in    (bin_in),
    .busy      (busy),
    .done      (done),
    .bcd_out   (bcd_out),
    .overflow  (overflow),
`ifdef BCD_BLANK_MASK_EN
    .blank_mask(blank_mask),
`endif
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {mask, overflow, bcd} from decimal arithmetic on the value.
  function automatic logic [EW-1:0] model(input int unsigned v);
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]   mask;
    logic                ovf;
    int unsigned         t;
    int unsigned         p;
    bcd  = '0;
    mask = '0;
    ovf  = (v > 999999);
    if (ovf) begin
      for (int i = 0; i < DIGITS; i++) bcd[4*i +: 4] = 4'd9;
    end else begin
      t = v;
      for (int i = 0; i < DIGITS; i++) begin
        bcd[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
      p = 1;
      for (int i = 1; i < DIGITS; i++) begin
        p = p * 10;
        mask[i] = (v < p);
      end
    end
    return {mask, ovf, bcd};
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Compare the result published with a done pulse against the scoreboard.
  task automatic check_done();
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("bcd_out", 32'(bcd_out), 32'(e[4*DIGITS-1:0]));
      check("overflow", 32'(overflow), 32'(e[4*DIGITS]));
      check("busy_at_done", 32'(busy), 32'd0);
`ifdef BCD_BLANK_MASK_EN
      check("blank_mask", 32'(blank_mask), 32'(e[EW-1 -: DIGITS]));
`endif
    end
  endtask

  // Drive one conversion and wait (bounded) for its done pulse.
  task automatic run_conv(input int unsigned v);
    int lat;
    int busy_n;
    logic hold_bad;
    logic [4*DIGITS-1:0] prev;
    start  = 1'b1;
    bin_in = BIN_W'(v);
    exp_q.push_back(model(v));
    prev = bcd_out;
    tick();
    start    = 1'b0;
    bin_in   = BIN_W'($urandom_range(0, 1048575));
    busy_n   = int'(busy);
    lat      = 0;
    hold_bad = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
      busy_n += int'(busy);
      if (bcd_out !== prev) hold_bad = 1'b1;
    end
    if (lat == 0) begin
      check("done_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end else begin
      check("latency", 32'(lat), 32'(LAT));
      check("busy_cycles", 32'(busy_n), 32'(LAT));
      check("bcd_hold", 32'(hold_bad), 32'd0);
      check_done();
    end
  endtask

  initial begin
    int first;
    int second;
    int extra;
    int unsigned v;

    n_checks = 0;
    n_errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) tick();

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    tick();

    // Zero, then a typical value with done-pulse width check
    run_conv(0);
    run_conv(123456);
    tick();
    check("done_width", 32'(done), 32'd0);

    // Largest displayable value and clamp boundary
    run_conv(999999);
    run_conv(1000000);
    run_conv(1048575);

    // Starts while busy are ignored; start during done is accepted
    start  = 1'b1;
    bin_in = BIN_W'(654321);
    exp_q.push_back(model(654321));
    tick();
    start = 1'b0;
    first = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      start = 1'b0;
      if (done) begin
        first = k;
        break;
      end
      if (k == 4 || k == 19 || k == 20) begin
        start  = 1'b1;
        bin_in = BIN_W'(111111);
      end
    end
    check("busy_start_lat", 32'(first), 32'(LAT));
    if (first != 0) check_done();
    else exp_q.delete();
    start  = 1'b1;
    bin_in = BIN_W'(42);
    exp_q.push_back(model(42));
    tick();
    start  = 1'b0;
    second = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (done) begin
        second = k + 1;
        break;
      end
    end
    check("b2b_spacing", 32'(second), 32'(LAT + 1));
    if (second != 0) check_done();
    else exp_q.delete();
`ifdef BCD_BLANK_MASK_EN
    check("mask_42", 32'(blank_mask), 32'b111100);
`endif
    extra = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      extra += int'(done);
    end
    check("no_extra_done", 32'(extra), 32'd0);

    // Reset in the middle of a conversion
    start  = 1'b1;
    bin_in = BIN_W'(777777);
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_bcd", 32'(bcd_out), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    extra = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      extra += int'(done);
    end
    check("post_rst_no_done", 32'(extra), 32'd0);
    check("post_rst_bcd", 32'(bcd_out), 32'd0);
    run_conv(314159);
    run_conv(0);
`ifdef BCD_BLANK_MASK_EN
    check("mask_0", 32'(blank_mask), 32'b111110);
`endif

    // Random values, weighted toward the clamp boundary, random gaps
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(999990, 1000010);
        1:       v = $urandom_range(0, 999);
        default: v = $urandom_range(0, 1048575);
      endcase
      run_conv(v);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
